// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline constants: opcodes, write-back select codes, load func3 codes.
package riscv_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OP_IMM = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        WB_SEL_ALU  = 2'b00,
        WB_SEL_LOAD = 2'b01,
        WB_SEL_PC4  = 2'b10,
        WB_SEL_NONE = 2'b11
    } wb_sel_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/wb_result_fifo.sv
// Synchronous FIFO with occupancy count; holds long-latency results awaiting a write slot.
// The caller never pushes when count == DEPTH nor pops when count == 0.
module wb_result_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 37,
    localparam int unsigned CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic [CW-1:0]    count
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;

    // Pointer advance with wrap at DEPTH (handles non-power-of-two depths).
    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Next pointers and occupancy.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = ptr_next(wr_ptr_q);
        if (pop)  rd_ptr_d = ptr_next(rd_ptr_q);
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are meaningless while count is zero, so no reset.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wdata;
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: result select, load extension and arbitration of the single
// register-file write port between the pipeline and the long-latency result FIFO.
module wb_stage
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned MC_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            wb_valid,
    input  logic            wb_regwrite,
    input  logic [4:0]      wb_rd,
    input  logic [1:0]      wb_sel,
    input  logic [2:0]      wb_func3,
    input  logic [1:0]      wb_addr_lo,
    input  logic [XLEN-1:0] alu_result,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic [XLEN-1:0] pc,
    input  logic            mc_valid,
    output logic            mc_ready,
    input  logic [4:0]      mc_rd,
    input  logic [XLEN-1:0] mc_result,
    output logic            stall_req,
    output logic            RegWrite,
    output logic [4:0]      write_register,
    output logic [XLEN-1:0] write_data
);

    localparam int unsigned CW = $clog2(MC_DEPTH + 1);
    localparam int unsigned FW = XLEN + 5;

    logic [7:0]      byte_lane_c;
    logic [15:0]     half_lane_c;
    logic [XLEN-1:0] load_data_c;
    logic [XLEN-1:0] pipe_data_c;
    logic            pw_c;
    logic            full_c;
    logic            fifo_push_c;
    logic            fifo_pop_c;
    logic [FW-1:0]   fifo_head;
    logic [CW-1:0]   fifo_count;

    logic            regwrite_q, regwrite_d;
    logic [4:0]      wreg_q, wreg_d;
    logic [XLEN-1:0] wdata_q, wdata_d;

    // Load lane extraction and sign/zero extension.
    always_comb begin
        case (wb_addr_lo)
            2'd1:    byte_lane_c = mem_rdata[15:8];
            2'd2:    byte_lane_c = mem_rdata[23:16];
            2'd3:    byte_lane_c = mem_rdata[31:24];
            default: byte_lane_c = mem_rdata[7:0];
        endcase
        half_lane_c = wb_addr_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (wb_func3)
            F3_LB:   load_data_c = {{(XLEN - 8){byte_lane_c[7]}}, byte_lane_c};
            F3_LH:   load_data_c = {{(XLEN - 16){half_lane_c[15]}}, half_lane_c};
            F3_LBU:  load_data_c = {{(XLEN - 8){1'b0}}, byte_lane_c};
            F3_LHU:  load_data_c = {{(XLEN - 16){1'b0}}, half_lane_c};
            default: load_data_c = mem_rdata;
        endcase
    end

    // Pipeline result mux and write request.
    always_comb begin
        case (wb_sel_e'(wb_sel))
            WB_SEL_LOAD: pipe_data_c = load_data_c;
            WB_SEL_PC4:  pipe_data_c = pc + XLEN'(4);
            default:     pipe_data_c = alu_result;
        endcase
        pw_c = wb_valid & wb_regwrite & (wb_rd != 5'd0) & (wb_sel_e'(wb_sel) != WB_SEL_NONE);
    end

    // Flow control depends on occupancy only; rd == 0 results are dropped on entry.
    assign full_c      = (fifo_count == CW'(MC_DEPTH));
    assign mc_ready    = ~full_c;
    assign stall_req   = full_c;
    assign fifo_push_c = mc_valid & mc_ready & (mc_rd != 5'd0);

    wb_result_fifo #(
        .DEPTH (MC_DEPTH),
        .WIDTH (FW)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push_c),
        .wdata ({mc_rd, mc_result}),
        .pop   (fifo_pop_c),
        .rdata (fifo_head),
        .count (fifo_count)
    );

    // Write-port arbitration: full FIFO first, then pipeline, then FIFO drain.
    always_comb begin
        regwrite_d = 1'b0;
        wreg_d     = wreg_q;
        wdata_d    = wdata_q;
        fifo_pop_c = 1'b0;
        if (full_c) begin
            regwrite_d = 1'b1;
            wreg_d     = fifo_head[XLEN +: 5];
            wdata_d    = fifo_head[XLEN-1:0];
            fifo_pop_c = 1'b1;
        end else if (pw_c) begin
            regwrite_d = 1'b1;
            wreg_d     = wb_rd;
            wdata_d    = pipe_data_c;
        end else if (fifo_count != '0) begin
            regwrite_d = 1'b1;
            wreg_d     = fifo_head[XLEN +: 5];
            wdata_d    = fifo_head[XLEN-1:0];
            fifo_pop_c = 1'b1;
        end
    end

    // Registered write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regwrite_q <= 1'b0;
            wreg_q     <= '0;
            wdata_q    <= '0;
        end else begin
            regwrite_q <= regwrite_d;
            wreg_q     <= wreg_d;
            wdata_q    <= wdata_d;
        end
    end

    assign RegWrite       = regwrite_q;
    assign write_register = wreg_q;
    assign write_data     = wdata_q;

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: expected writes are queued at stimulus time and
// a negedge monitor pops and compares every register-file write.
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wb_valid, wb_regwrite;
    logic [4:0]  wb_rd;
    logic [1:0]  wb_sel;
    logic [2:0]  wb_func3;
    logic [1:0]  wb_addr_lo;
    logic [31:0] alu_result, mem_rdata, pc;
    logic        mc_valid, mc_ready;
    logic [4:0]  mc_rd;
    logic [31:0] mc_result;
    logic        stall_req, RegWrite;
    logic [4:0]  write_register;
    logic [31:0] write_data;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [36:0] exp_q [$];
    logic [36:0] exp_e;

    wb_stage #(.XLEN(32), .MC_DEPTH(2)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .wb_valid       (wb_valid),
        .wb_regwrite    (wb_regwrite),
        .wb_rd          (wb_rd),
        .wb_sel         (wb_sel),
        .wb_func3       (wb_func3),
        .wb_addr_lo     (wb_addr_lo),
        .alu_result     (alu_result),
        .mem_rdata      (mem_rdata),
        .pc             (pc),
        .mc_valid       (mc_valid),
        .mc_ready       (mc_ready),
        .mc_rd          (mc_rd),
        .mc_result      (mc_result),
        .stall_req      (stall_req),
        .RegWrite       (RegWrite),
        .write_register (write_register),
        .write_data     (write_data)
    );

    always #5 clk = ~clk;

    // Monitor: every write must match the head of the expected queue.
    always @(negedge clk) begin
        if (rst_n && RegWrite) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write: got rd=%0d data=%h, required no write", write_register, write_data);
            end else begin
                exp_e = exp_q.pop_front();
                if ({write_register, write_data} !== exp_e) begin
                    n_fail++;
                    $display("FAIL write: got rd=%0d data=%h, required rd=%0d data=%h",
                             write_register, write_data, exp_e[36:32], exp_e[31:0]);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic expw(input logic [4:0] rd, input logic [31:0] d);
        exp_q.push_back({rd, d});
    endtask

    task automatic set_pipe(input logic v, input logic rw, input logic [4:0] rd, input logic [1:0] sel,
                            input logic [2:0] f3, input logic [1:0] alo, input logic [31:0] alu,
                            input logic [31:0] mem, input logic [31:0] pcv);
        wb_valid = v; wb_regwrite = rw; wb_rd = rd; wb_sel = sel; wb_func3 = f3;
        wb_addr_lo = alo; alu_result = alu; mem_rdata = mem; pc = pcv;
    endtask

    task automatic set_mc(input logic v, input logic [4:0] rd, input logic [31:0] d);
        mc_valid = v; mc_rd = rd; mc_result = d;
    endtask

    task automatic idle();
        set_pipe(1'b0, 1'b0, 5'd0, 2'b00, 3'b000, 2'd0, 32'h0, 32'h0, 32'h0);
        set_mc(1'b0, 5'd0, 32'h0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    logic [4:0]  p_rd  [5];
    logic [31:0] p_dat [5];
    logic [4:0]  m_rd  [3];
    logic [31:0] m_dat [3];
    logic        stall_exp [8];

    initial begin
        int pi, mi;
        logic st, acc;
        rst_n = 1'b0;
        idle();
        #3;
        chk("reset_regwrite", 32'(RegWrite), 32'h0);
        chk("reset_wreg", 32'(write_register), 32'h0);
        chk("reset_wdata", write_data, 32'h0);
        chk("reset_mc_ready", 32'(mc_ready), 32'h1);
        chk("reset_stall", 32'(stall_req), 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // ALU write, load variants, JAL with PC wrap
        set_pipe(1, 1, 5'd5, 2'b00, 3'b000, 2'd0, 32'h0000_1234, 32'h0, 32'h0); expw(5'd5, 32'h0000_1234); tick();
        set_pipe(1, 1, 5'd6, 2'b01, 3'b000, 2'd3, 32'h0, 32'h80FF_7F01, 32'h0); expw(5'd6, 32'hFFFF_FF80); tick();
        set_pipe(1, 1, 5'd7, 2'b01, 3'b100, 2'd3, 32'h0, 32'h80FF_7F01, 32'h0); expw(5'd7, 32'h0000_0080); tick();
        set_pipe(1, 1, 5'd8, 2'b01, 3'b101, 2'd2, 32'h0, 32'h80FF_7F01, 32'h0); expw(5'd8, 32'h0000_80FF); tick();
        set_pipe(1, 1, 5'd9, 2'b01, 3'b001, 2'd0, 32'h0, 32'h80FF_7F01, 32'h0); expw(5'd9, 32'h0000_7F01); tick();
        set_pipe(1, 1, 5'd10, 2'b01, 3'b001, 2'd2, 32'h0, 32'h80FF_7F01, 32'h0); expw(5'd10, 32'hFFFF_80FF); tick();
        set_pipe(1, 1, 5'd11, 2'b01, 3'b011, 2'd1, 32'h0, 32'h80FF_7F01, 32'h0); expw(5'd11, 32'h80FF_7F01); tick();
        set_pipe(1, 1, 5'd1, 2'b10, 3'b000, 2'd0, 32'h0, 32'h0, 32'hFFFF_FFFC); expw(5'd1, 32'h0000_0000); tick();
        // writes that must be suppressed: x0, reserved sel, invalid slot, no regwrite
        set_pipe(1, 1, 5'd0, 2'b00, 3'b000, 2'd0, 32'hDEAD_0000, 32'h0, 32'h0); tick();
        set_pipe(1, 1, 5'd3, 2'b11, 3'b000, 2'd0, 32'hDEAD_0003, 32'h0, 32'h0); tick();
        set_pipe(0, 1, 5'd4, 2'b00, 3'b000, 2'd0, 32'hDEAD_0004, 32'h0, 32'h0); tick();
        set_pipe(1, 0, 5'd4, 2'b00, 3'b000, 2'd0, 32'hDEAD_0005, 32'h0, 32'h0); tick();
        set_pipe(1, 1, 5'd12, 2'b01, 3'b000, 2'd1, 32'h0, 32'h80FF_7F01, 32'h0); expw(5'd12, 32'h0000_007F); tick();
        idle();
        @(negedge clk);
        tick();
        @(negedge clk);
        chk("hold_regwrite", 32'(RegWrite), 32'h0);
        chk("hold_wreg", 32'(write_register), 32'd12);
        chk("hold_wdata", write_data, 32'h0000_007F);

        // Idle drain: write two cycles after push
        tick();
        set_mc(1'b1, 5'd7, 32'h0000_00AA); expw(5'd7, 32'h0000_00AA);
        tick();
        set_mc(1'b0, 5'd0, 32'h0);
        @(negedge clk);
        chk("drain_wait_regwrite", 32'(RegWrite), 32'h0);
        chk("drain_mc_ready", 32'(mc_ready), 32'h1);
        tick();
        @(negedge clk);
        chk("drain_regwrite", 32'(RegWrite), 32'h1);
        tick();
        chk("drain_empty_stall", 32'(stall_req), 32'h0);
        // rd == 0 long-latency result is accepted and dropped
        set_mc(1'b1, 5'd0, 32'h0000_0055);
        tick();
        set_mc(1'b0, 5'd0, 32'h0);
        repeat (3) tick();

        // Saturation: pipeline writes every cycle plus three long-latency pushes
        for (int i = 0; i < 5; i++) begin p_rd[i] = 5'(14 + i); p_dat[i] = 32'h100 + 32'(i); end
        m_rd[0] = 5'd20; m_dat[0] = 32'hA0;
        m_rd[1] = 5'd21; m_dat[1] = 32'hB0;
        m_rd[2] = 5'd22; m_dat[2] = 32'hC0;
        stall_exp = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        expw(p_rd[0], p_dat[0]); expw(p_rd[1], p_dat[1]); expw(m_rd[0], m_dat[0]);
        expw(p_rd[2], p_dat[2]); expw(m_rd[1], m_dat[1]); expw(p_rd[3], p_dat[3]);
        expw(p_rd[4], p_dat[4]); expw(m_rd[2], m_dat[2]);
        pi = 0; mi = 0;
        for (int c = 0; c < 8; c++) begin
            if (pi < 5) set_pipe(1, 1, p_rd[pi], 2'b00, 3'b000, 2'd0, p_dat[pi], 32'h0, 32'h0);
            else        set_pipe(0, 0, 5'd0, 2'b00, 3'b000, 2'd0, 32'h0, 32'h0, 32'h0);
            if (mi < 3) set_mc(1'b1, m_rd[mi], m_dat[mi]);
            else        set_mc(1'b0, 5'd0, 32'h0);
            chk($sformatf("sat_stall_c%0d", c), 32'(stall_req), 32'(stall_exp[c]));
            chk($sformatf("sat_ready_c%0d", c), 32'(mc_ready), 32'(!stall_exp[c]));
            st  = stall_req;
            acc = mc_valid & mc_ready;
            tick();
            if (!st && pi < 5) pi++;
            if (acc) mi++;
        end
        idle();
        repeat (2) tick();
        chk("sat_end_ready", 32'(mc_ready), 32'h1);

        // Async reset with FIFO full and a write on the port
        set_pipe(1, 1, 5'd23, 2'b00, 3'b000, 2'd0, 32'h5555, 32'h0, 32'h0); set_mc(1'b1, 5'd24, 32'h77);
        expw(5'd23, 32'h5555);
        tick();
        set_pipe(1, 1, 5'd25, 2'b00, 3'b000, 2'd0, 32'h6666, 32'h0, 32'h0); set_mc(1'b1, 5'd26, 32'h88);
        expw(5'd25, 32'h6666);
        tick();
        idle();
        @(negedge clk);
        chk("pre_reset_stall", 32'(stall_req), 32'h1);
        chk("pre_reset_regwrite", 32'(RegWrite), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_regwrite", 32'(RegWrite), 32'h0);
        chk("async_wreg", 32'(write_register), 32'h0);
        chk("async_wdata", write_data, 32'h0);
        chk("async_mc_ready", 32'(mc_ready), 32'h1);
        chk("async_stall", 32'(stall_req), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        set_pipe(1, 1, 5'd13, 2'b00, 3'b000, 2'd0, 32'h0000_BEEF, 32'h0, 32'h0);
        expw(5'd13, 32'h0000_BEEF);
        tick();
        idle();
        repeat (5) tick();
        @(negedge clk);

        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL leftover_expected: got %0d pending writes, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_stage.md
# wb_stage

Write-back stage of the five-stage RISC-V pipeline. Selects the result for the destination register (ALU result, extended load data or PC+4) and drives the single register-file write port consumed by the decode stage. The port is shared with a long-latency execution unit (divider and similar), whose results sit in a small FIFO until the pipeline leaves a write slot free. All write-port outputs are registered.

## Interface
Parameters:
- XLEN, 32, datapath width.
- MC_DEPTH, 2, long-latency result FIFO entries (≥1).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- wb_valid  in  1  MEM/WB slot holds an instruction.
- wb_regwrite  in  1  instruction writes rd.
- wb_rd  in  5  destination register.
- wb_sel  in  2  00 ALU, 01 load, 10 PC+4, 11 reserved (no write).
- wb_func3  in  3  load width/sign code.
- wb_addr_lo  in  2  load address bits [1:0].
- alu_result  in  XLEN  ALU result.
- mem_rdata  in  XLEN  raw aligned data-memory word.
- pc  in  XLEN  instruction PC.
- mc_valid  in  1  long-latency unit offers a result.
- mc_ready  out  1  FIFO accepts; equals (count < MC_DEPTH).
- mc_rd  in  5  long-latency destination.
- mc_result  in  XLEN  long-latency result.
- stall_req  out  1  count == MC_DEPTH; upstream holds MEM/WB stable.
- RegWrite  out  1  register-file write enable.
- write_register  out  5  write address.
- write_data  out  XLEN  write data.

## Operation
- Pipeline write request (pw): wb_valid & wb_regwrite & wb_rd != 0 & wb_sel != 11.
- Result mux: 00 alu_result; 01 extended load; 10 pc + 4 (modulo 2^XLEN).
- Load extension: byte lane = mem_rdata[8*addr_lo +: 8], halfword = mem_rdata[16*addr_lo[1] +: 16]. func3 000 LB sign, 001 LH sign, 010 LW, 100 LBU zero, 101 LHU zero; other codes treated as LW.
- FIFO push: mc_valid & mc_ready. Entries with mc_rd == 0 are accepted and discarded (never pushed).
- Port arbitration each cycle, in priority order:
  - count == MC_DEPTH: FIFO head is written, popped; pipeline input not consumed. Upstream re-presents it because stall_req = 1.
  - else pw: pipeline result written; FIFO untouched except push.
  - else count > 0: FIFO head written and popped.
  - else: RegWrite = 0; write_register and write_data hold their last values.
- Push and pop in the same cycle: count unchanged. Data ordering is strict FIFO.
- RAW ordering between FIFO entries and pipeline writes to the same rd is the scoreboard's responsibility, not this block's.

## Timing
- Latency: input visible at edge N gives the write-port output valid after edge N (one cycle). The register file captures it at edge N+1.
- mc_ready and stall_req are combinational from count only, with no combinational path from mc_valid or wb_*.
- Reset (rst_n low, asynchronous): RegWrite = 0, write_register = 0, write_data = 0, count = 0, read/write pointers = 0. As a result mc_ready = 1 and stall_req = 0.
- Reset mid-operation: FIFO contents are dropped and no write is issued on the first edge after release unless pw.
- Full with mc_valid: push is refused that cycle even though a pop occurs (ready was 0 at cycle start).
- Pointer wrap: modulo MC_DEPTH. Non-power-of-two depth must work.

## Structure
- Shared package riscv_pkg: opcode constants, WB_SEL_ALU/LOAD/PC4/NONE, func3 load codes (F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU).
- Sub-module wb_result_fifo (parameterised depth/width sync FIFO with count output) holds the long-latency results. Load extension and arbitration stay in wb_stage.

## Test plan
- ALU write: wb_valid = 1, regwrite = 1, rd = 5, sel = 00, alu_result = 0x1234 -> next cycle RegWrite = 1, write_register = 5, write_data = 0x1234.
- Loads: mem_rdata = 0x80FF7F01, addr_lo = 3, LB -> 0xFFFFFF80. Same word, LBU -> 0x00000080. addr_lo = 2, LHU -> 0x000080FF. LH addr_lo = 0 -> 0x00007F01.
- x0 and JAL: rd = 0, sel = 00 -> RegWrite = 0. rd = 1, sel = 10, pc = 0xFFFFFFFC -> write_data = 0x00000000.
- Idle drain: mc push rd = 7, value 0xAA with wb_valid = 0 -> write rd 7 = 0xAA two cycles after push. Count returns to 0.
- Saturation: pipeline writes every cycle plus 3 mc pushes (MC_DEPTH = 2) -> third push held (mc_ready = 0). stall_req rises at count = 2, head written in priority, held pipeline result written afterwards. No write lost or duplicated.
- Async reset with count = 2 and RegWrite = 1 -> all outputs 0, mc_ready = 1 immediately without a clock edge.
